// File: rtl/wb_matmul_master.sv
// Wishbone classic initiator that runs one 2x2 byte-matrix multiply on a memory-mapped
// multiplier: writes A and B, reads back the four 16-bit result elements, aborts on ack timeout.
module wb_matmul_master #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] c11_o,
  output logic [15:0] c12_o,
  output logic [15:0] c21_o,
  output logic [15:0] c22_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a transfer completes on the rising edge where cyc, stb and ack are all high;
  // address and write data are held from REQ entry until that edge.

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2, FIN = 2'd3} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [15:0] c11_q, c11_d, c12_q, c12_d, c21_q, c21_d, c22_q, c22_d;
  logic        err_q, err_d;
  logic        in_req;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      wait_q  <= 8'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      c11_q   <= 16'd0;
      c12_q   <= 16'd0;
      c21_q   <= 16'd0;
      c22_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c11_q   <= c11_d;
      c12_q   <= c12_d;
      c21_q   <= c21_d;
      c22_q   <= c22_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    a_d     = a_q;
    b_d     = b_q;
    c11_d   = c11_q;
    c12_d   = c12_q;
    c21_d   = c21_q;
    c22_d   = c22_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          err_d   = 1'b0;
          op_d    = 3'd0;
          wait_d  = 8'd0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (wbm_ack_i) begin
          case (op_q)
            3'd2:    c11_d = wbm_dat_i[15:0];
            3'd3:    c12_d = wbm_dat_i[15:0];
            3'd4:    c21_d = wbm_dat_i[15:0];
            3'd5:    c22_d = wbm_dat_i[15:0];
            default: ;
          endcase
          wait_d  = 8'd0;
          state_d = (op_q == 3'd5) ? FIN : GAP;
        end else if (wait_q == TO_LAST) begin
          // Unread result registers keep whatever the previous job left in them.
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      GAP: begin
        op_d    = op_q + 3'd1;
        wait_d  = 8'd0;
        state_d = REQ;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode straight from registers so reset removes them without waiting for a clock.
  assign in_req    = (state_q == REQ);
  assign wbm_cyc_o = in_req;
  assign wbm_stb_o = in_req;
  assign wbm_we_o  = in_req && (op_q < 3'd2);
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = in_req ? (BASE_ADDR + {27'd0, op_q, 2'b00}) : 32'd0;
  assign wbm_dat_o = (in_req && op_q == 3'd0) ? a_q :
                     (in_req && op_q == 3'd1) ? b_q : 32'd0;

  assign busy_o      = (state_q == REQ) || (state_q == GAP);
  assign done_o      = (state_q == FIN);
  assign err_o       = err_q;
  assign c11_o       = c11_q;
  assign c12_o       = c12_q;
  assign c21_o       = c21_q;
  assign c22_o       = c22_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_matmul_master.sv
// Bench for wb_matmul_master: a Wishbone responder that behaves like the multiplier,
// a transaction scoreboard, a table of jobs and hand-written timeout/reset sequences.
module tb_wb_matmul_master;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk, rst_n, start_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] c11_o, c12_o, c21_o, c22_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i;
  logic [1:0]  dbg_state_o;

  wb_matmul_master #(.BASE_ADDR(BASE), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .c11_o(c11_o), .c12_o(c12_o), .c21_o(c21_o), .c22_o(c22_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .dbg_state_o(dbg_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [64:0] exp_q[$];

  int          resp_waits = 0;
  bit          noack_en = 0;
  logic [31:0] noack_adr = 32'd0;
  bit          spurious = 0;
  int          resp_cnt = 0;
  int          txn_cnt = 0;
  logic [31:0] ra = 32'd0, rb = 32'd0;
  logic [31:0] hold_adr, hold_dat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mm(input logic [31:0] a, input logic [31:0] b, input int idx);
    logic [7:0]  a11, a12, a21, a22, b11, b12, b21, b22;
    logic [15:0] r;
    {a22, a21, a12, a11} = a;
    {b22, b21, b12, b11} = b;
    case (idx)
      0:       r = a11 * b11 + a12 * b21;
      1:       r = a11 * b12 + a12 * b22;
      2:       r = a21 * b11 + a22 * b21;
      default: r = a21 * b12 + a22 * b22;
    endcase
    return r;
  endfunction

  // Responder: drives ack/data on the falling edge so they are stable at the next rising edge.
  always @(negedge clk) begin
    logic [64:0] got, e;
    int idx;
    if (wbm_cyc_o && wbm_stb_o) begin
      if (resp_cnt == 0) begin
        hold_adr = wbm_adr_o;
        hold_dat = wbm_dat_o;
      end else begin
        check("adr_stable", wbm_adr_o, hold_adr);
        check("dat_stable", wbm_dat_o, hold_dat);
      end
      check("sel_f", {28'd0, wbm_sel_o}, 32'hF);
      if (noack_en && wbm_adr_o == noack_adr) begin
        wbm_ack_i = 1'b0;
        resp_cnt++;
      end else if (resp_cnt >= resp_waits) begin
        wbm_ack_i = 1'b1;
        resp_cnt = 0;
        txn_cnt++;
        got = {wbm_we_o, wbm_adr_o, wbm_dat_o};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL txn_unexpected actual=%h required=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL txn actual=%h required=%h", got, e);
          end
        end
        if (wbm_we_o) begin
          if (wbm_adr_o == BASE) ra = wbm_dat_o;
          else rb = wbm_dat_o;
          wbm_dat_i = 32'd0;
        end else begin
          idx = int'((wbm_adr_o - BASE - 32'd8) >> 2);
          wbm_dat_i = {16'($urandom), mm(ra, rb, idx)};
        end
      end else begin
        wbm_ack_i = 1'b0;
        resp_cnt++;
      end
    end else begin
      wbm_ack_i = spurious;
      wbm_dat_i = spurious ? 32'hFFFF_FFFF : 32'd0;
      resp_cnt = 0;
    end
  end

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input int n_txn);
    for (int i = 0; i < n_txn; i++) begin
      if (i == 0)      exp_q.push_back({1'b1, BASE, a});
      else if (i == 1) exp_q.push_back({1'b1, BASE + 32'd4, b});
      else             exp_q.push_back({1'b0, BASE + 32'(4 * i), 32'd0});
    end
  endtask

  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int n_txn,
                         input bit pulse_busy, input bit pulse_fin,
                         output int done_cyc, output logic err_at_done, output logic cyc_at_done);
    push_exp(a, b, n_txn);
    txn_cnt = 0;
    done_cyc = -1;
    err_at_done = 1'b0;
    cyc_at_done = 1'b0;
    @(negedge clk);
    start_i = 1'b1; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0; a_i = $urandom; b_i = $urandom;
    for (int n = 1; n <= 200; n++) begin
      if (n == 1) begin
        check("busy_c1", {31'd0, busy_o}, 32'd1);
        check("err_clr_c1", {31'd0, err_o}, 32'd0);
      end
      start_i = pulse_busy && (n == 4);
      if (done_o) begin
        done_cyc = n;
        err_at_done = err_o;
        cyc_at_done = wbm_cyc_o | wbm_stb_o;
        if (pulse_fin) start_i = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    start_i = 1'b0;
    check("post_fin", {28'd0, busy_o, done_o, wbm_cyc_o, 1'b0}, 32'd0);
    check("post_fin_state", {30'd0, dbg_state_o}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("idle_after", {30'd0, busy_o, wbm_cyc_o}, 32'd0);
    check("txn_count", 32'(txn_cnt), 32'(n_txn));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_results(input string tag, input logic [31:0] a, input logic [31:0] b);
    check({tag, "_c11"}, {16'd0, c11_o}, {16'd0, mm(a, b, 0)});
    check({tag, "_c12"}, {16'd0, c12_o}, {16'd0, mm(a, b, 1)});
    check({tag, "_c21"}, {16'd0, c21_o}, {16'd0, mm(a, b, 2)});
    check({tag, "_c22"}, {16'd0, c22_o}, {16'd0, mm(a, b, 3)});
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          waits;
    bit          spur;
    bit          pulse_busy;
    bit          pulse_fin;
    int          exp_done;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int          dc;
    logic        ed, cd;
    logic [15:0] p11, p12, p21, p22;

    vecs[0] = '{32'h0403_0201, 32'h0807_0605, 0, 0, 0, 0, 12};
    vecs[1] = '{32'h0403_0201, 32'h0807_0605, 3, 0, 0, 0, 30};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 0, 18};
    vecs[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 2, 0, 1, 1, 24};
    vecs[4] = '{32'hA5A5_5A5A, 32'h0F0F_F0F0, 0, 1, 0, 0, 12};

    rst_n = 1'b0; start_i = 1'b0; a_i = 32'd0; b_i = 32'd0;
    wbm_ack_i = 1'b0; wbm_dat_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
    check("rst_sel", {28'd0, wbm_sel_o}, 32'hF);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat", wbm_dat_o, 32'd0);
    check("rst_flags", {29'd0, busy_o, done_o, err_o}, 32'd0);
    check("rst_c", {c11_o, c12_o} | {c21_o, c22_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Spurious ack in IDLE
    spurious = 1;
    repeat (4) begin @(posedge clk); #1; end
    check("spur_idle_state", {29'd0, dbg_state_o, busy_o}, 32'd0);
    check("spur_idle_c", {c11_o, c22_o}, 32'd0);
    spurious = 0;

    for (int i = 0; i < 5; i++) begin
      resp_waits = vecs[i].waits;
      spurious = vecs[i].spur;
      run_job(vecs[i].a, vecs[i].b, 6, vecs[i].pulse_busy, vecs[i].pulse_fin, dc, ed, cd);
      spurious = 0;
      check($sformatf("v%0d_done_cyc", i), 32'(dc), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_err", i), {31'd0, ed}, 32'd0);
      check_results($sformatf("v%0d", i), vecs[i].a, vecs[i].b);
    end

    // Timeout on op2: results must keep the previous job's values
    p11 = c11_o; p12 = c12_o; p21 = c21_o; p22 = c22_o;
    resp_waits = 0; noack_en = 1; noack_adr = BASE + 32'h8;
    run_job(32'h1111_2222, 32'h3333_4444, 2, 0, 0, dc, ed, cd);
    noack_en = 0;
    check("to_done_cyc", 32'(dc), 32'd9);
    check("to_err_at_fin", {31'd0, ed}, 32'd1);
    check("to_cyc_at_fin", {31'd0, cd}, 32'd0);
    check("to_err_hold", {31'd0, err_o}, 32'd1);
    check("to_c_keep", {c11_o, c12_o}, {p11, p12});
    check("to_c_keep2", {c21_o, c22_o}, {p21, p22});

    run_job(vecs[0].a, vecs[0].b, 6, 0, 0, dc, ed, cd);
    check("after_to_done", 32'(dc), 32'd12);
    check("after_to_err", {31'd0, err_o}, 32'd0);
    check_results("after_to", vecs[0].a, vecs[0].b);

    // Reset during op3 REQ (cycle 7), then late ack after release
    resp_waits = 0;
    push_exp(vecs[2].a, vecs[2].b, 6);
    @(negedge clk);
    start_i = 1'b1; a_i = vecs[2].a; b_i = vecs[2].b;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("mid_op3_adr", wbm_adr_o, BASE + 32'hC);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bus", {29'd0, wbm_cyc_o, wbm_stb_o, busy_o}, 32'd0);
    check("mid_rst_done", {31'd0, done_o}, 32'd0);
    check("mid_rst_c", {c11_o, c12_o} | {c21_o, c22_o}, 32'd0);
    exp_q.delete();
    spurious = 1;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("late_ack_idle", {29'd0, busy_o, done_o, wbm_cyc_o}, 32'd0);
    end
    check("late_ack_c", {c11_o, c12_o} | {c21_o, c22_o}, 32'd0);
    spurious = 0;
    run_job(vecs[0].a, vecs[0].b, 6, 0, 0, dc, ed, cd);
    check("post_rst_done", 32'(dc), 32'd12);
    check_results("post_rst", vecs[0].a, vecs[0].b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_matmul_master.md
WB_MATMUL_MASTER -- requirements
Module: wb_matmul_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning the byte address of the multiplier's A register; register offsets are added to it.
REQ-002 SHALL have parameter TIMEOUT, default 255, range 1..255, meaning the maximum number of REQ cycles allowed without an ack.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 wb_clk_i  in  1  clock; all state changes on the rising edge.
REQ-005 wb_rst_ni  in  1  asynchronous, active-low reset.
REQ-006 start_i  in  1  single-cycle request to run one 2x2 multiply.
REQ-007 a_i  in  32  packed A operand: [7:0] A11, [15:8] A12, [23:16] A21, [31:24] A22.
REQ-008 b_i  in  32  packed B operand, using the same packing as a_i.
REQ-009 busy_o  out  1  high while a job is in progress.
REQ-010 done_o  out  1  one-cycle pulse at job end, whether the job succeeded or aborted.
REQ-011 err_o  out  1  set when the job aborted on timeout.
REQ-012 c11_o, c12_o, c21_o, c22_o  out  16 each  result elements.
REQ-013 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic initiator controls.
REQ-014 wbm_sel_o  out  4  byte selects; always 4'hF.
REQ-015 wbm_adr_o  out  32  address; wbm_dat_o  out  32  write data.
REQ-016 wbm_dat_i  in  32  read data; wbm_ack_i  in  1  responder ack.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, GAP and FIN, plus a 3-bit operation index op (0..5).
REQ-018 In IDLE, start_i=1 SHALL latch a_i and b_i, clear err_o, set op=0 and go to REQ; start_i SHALL be ignored in all other states.
REQ-019 The op sequence SHALL be: 0 write a at +0x00; 1 write b at +0x04; 2 read +0x08 -> c11_o; 3 read +0x0C -> c12_o; 4 read +0x10 -> c21_o; 5 read +0x14 -> c22_o.
REQ-020 In REQ, cyc and stb SHALL be 1, wbm_we_o SHALL be 1 for op 0..1 and 0 otherwise, and wbm_adr_o and wbm_dat_o SHALL stay stable until ack.
REQ-021 In states other than REQ, cyc, stb and we SHALL be 0; wbm_dat_o SHALL be 0 for reads and outside REQ.
REQ-022 Ack SHALL be sampled at the rising edge while in REQ; ack outside REQ SHALL be ignored.
REQ-023 On ack during a read, wbm_dat_i[15:0] SHALL be registered into the selected c*_o and bits [31:16] discarded.
REQ-024 On ack with op<5, the FSM SHALL go to GAP (exactly one idle bus cycle), then to REQ with op+1.
REQ-025 On ack with op=5, the FSM SHALL go to FIN.
REQ-026 A wait counter SHALL reset on entry to REQ and increment on each REQ cycle without ack.
REQ-027 On the TIMEOUT-th consecutive REQ cycle with no ack, the FSM SHALL drop cyc/stb at the next edge, set err_o=1 and go to FIN.
REQ-028 On timeout, c*_o registers not yet read SHALL keep their prior values.
REQ-029 FIN SHALL last one cycle with done_o=1 and then return to IDLE.
REQ-030 busy_o SHALL be 1 exactly in REQ and GAP.
REQ-031 err_o SHALL hold until the next accepted start_i.
REQ-032 Latency with zero-wait acks: start sampled at edge 0 -> REQ for op0 in cycle 1, REQ for op5 in cycle 11, done_o in cycle 12; total 12 cycles.
REQ-033 When start_i coincides with FIN, it SHALL be ignored; a new start is accepted only in IDLE.

Reset
REQ-034 Asserting wb_rst_ni low SHALL immediately force IDLE; all outputs 0 (wbm_sel_o = 4'hF); c*_o = 0; err_o = 0; op and the wait counter cleared.
REQ-035 Reset asserted mid-transaction SHALL drop cyc/stb asynchronously with no done_o pulse; a late ack after reset release SHALL be ignored.

Verification
REQ-036 Zero-wait responder model, a_i=32'h04030201, b_i=32'h08070605 -> writes seen at +0x00 and +0x04, c11_o=0x0013, c12_o=0x0016, c21_o=0x002B, c22_o=0x0032, done_o in cycle 12, err_o=0.
REQ-037 Responder adds 3 wait states per access -> same results, done_o in cycle 30, address and data stable throughout each REQ.
REQ-038 TIMEOUT=4, responder never acks op2 -> err_o=1 and done_o 5 cycles after op2's REQ starts (4 REQ cycles + FIN), c11_o..c22_o unchanged, cyc=0.
REQ-039 start_i pulsed while busy, and start_i coincident with FIN -> both ignored; exactly 6 bus transactions per accepted start.
REQ-040 wb_rst_ni low during op3 REQ -> cyc/stb/busy_o = 0 in the same cycle, all c*_o = 0; a following start runs a clean full sequence.
REQ-041 Spurious wbm_ack_i in IDLE and GAP -> no state change and no result update.
